pipelined_barrel_shifter: RTL and testbench

- Parametrised, pipelined successor to the 32-bit combinational arithmetic right shifter.
- Supports logical left, logical right, arithmetic right and rotate right, selected per operation.
- Shifts by one log2 level per pipeline stage, with a valid/ready handshake on both sides.
- Sits between the register-read stage and the ALU result mux; multi-cycle shift ops are accepted when in_ready is high.

---
 rtl/pipelined_barrel_shifter_if.sv | 38 +++
 rtl/pipelined_barrel_shifter.sv | 133 +++++++++++++
 tb/tb_pipelined_barrel_shifter.sv | 209 ++++++++++++++++++++
 3 files changed

// File: rtl/pipelined_barrel_shifter_if.sv
// Operand/result handshake bundle for pipelined_barrel_shifter.
// out_carry exists only when SHIFTER_CARRY_OUT_EN is defined.
interface pipelined_barrel_shifter_if #(
    parameter int WIDTH = 32,
    parameter int TAG_W = 5
);
    localparam int SHW = $clog2(WIDTH);

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic [SHW-1:0]   in_shamt;
    logic [1:0]       in_op;
    logic [TAG_W-1:0] in_tag;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic [TAG_W-1:0] out_tag;
`ifdef SHIFTER_CARRY_OUT_EN
    logic             out_carry;
`endif

    modport slave (
        input  in_valid, in_data, in_shamt, in_op, in_tag, out_ready,
        output in_ready, out_valid, out_data, out_tag
`ifdef SHIFTER_CARRY_OUT_EN
        , output out_carry
`endif
    );

    modport master (
        output in_valid, in_data, in_shamt, in_op, in_tag, out_ready,
        input  in_ready, out_valid, out_data, out_tag
`ifdef SHIFTER_CARRY_OUT_EN
        , input out_carry
`endif
    );
endinterface

// File: rtl/pipelined_barrel_shifter.sv
// Log-depth pipelined shifter (SLL/SRL/SRA/ROR), one shift level per stage, global stall.
// Optional last-shifted-out bit on out_carry when SHIFTER_CARRY_OUT_EN is defined.
module pipelined_barrel_shifter #(
    parameter int WIDTH = 32,
    parameter int TAG_W = 5
) (
    input logic                      clk,
    input logic                      rst_n,
    pipelined_barrel_shifter_if.slave bus
);
    localparam int SHW = $clog2(WIDTH);

    typedef enum logic [1:0] {OP_SLL = 2'b00, OP_SRL = 2'b01, OP_SRA = 2'b10, OP_ROR = 2'b11} op_e;

    logic           advance;
    logic [SHW:0]   vld_pipe;
    logic [SHW-1:0] vld_pipe_d, vld_pipe_q;

    assign advance      = !vld_pipe_q[SHW-1] || bus.out_ready;
    assign bus.in_ready = advance;
    // vld_pipe[k] is the valid bit entering stage k
    assign vld_pipe     = {vld_pipe_q, bus.in_valid};

    always_comb begin
        vld_pipe_d = vld_pipe[SHW-1:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)       vld_pipe_q <= '0;
        else if (advance) vld_pipe_q <= vld_pipe_d;
    end

    for (genvar k = 0; k < SHW; k++) begin : g_stg
        localparam int LVL = SHW - 1 - k;
        localparam int AMT = 1 << LVL;

        logic [WIDTH-1:0] src_data, data_d, data_q;
        logic [SHW-1:0]   src_shamt, shamt_d, shamt_q;
        op_e              src_op, op_d, op_q;
        logic [TAG_W-1:0] src_tag, tag_d, tag_q;
        logic             src_sign, sign_d, sign_q;
`ifdef SHIFTER_CARRY_OUT_EN
        logic             src_carry, carry_d, carry_q;
`endif

        if (k == 0) begin : g_head
            assign src_data  = bus.in_data;
            assign src_shamt = bus.in_shamt;
            assign src_op    = op_e'(bus.in_op);
            assign src_tag   = bus.in_tag;
            // SRA fill comes from the original operand, not the shifted MSB
            assign src_sign  = bus.in_data[WIDTH-1];
`ifdef SHIFTER_CARRY_OUT_EN
            assign src_carry = 1'b0;
`endif
        end else begin : g_link
            assign src_data  = g_stg[k-1].data_q;
            assign src_shamt = g_stg[k-1].shamt_q;
            assign src_op    = g_stg[k-1].op_q;
            assign src_tag   = g_stg[k-1].tag_q;
            assign src_sign  = g_stg[k-1].sign_q;
`ifdef SHIFTER_CARRY_OUT_EN
            assign src_carry = g_stg[k-1].carry_q;
`endif
        end

        always_comb begin
            data_d  = data_q;
            shamt_d = shamt_q;
            op_d    = op_q;
            tag_d   = tag_q;
            sign_d  = sign_q;
`ifdef SHIFTER_CARRY_OUT_EN
            carry_d = carry_q;
`endif
            if (vld_pipe[k]) begin
                data_d  = src_data;
                shamt_d = src_shamt;
                op_d    = src_op;
                tag_d   = src_tag;
                sign_d  = src_sign;
`ifdef SHIFTER_CARRY_OUT_EN
                carry_d = src_carry;
`endif
                if (src_shamt[LVL]) begin
                    unique case (src_op)
                        OP_SLL: data_d = {src_data[WIDTH-1-AMT:0], {AMT{1'b0}}};
                        OP_SRL: data_d = {{AMT{1'b0}}, src_data[WIDTH-1:AMT]};
                        OP_SRA: data_d = {{AMT{src_sign}}, src_data[WIDTH-1:AMT]};
                        OP_ROR: data_d = {src_data[AMT-1:0], src_data[WIDTH-1:AMT]};
                    endcase
`ifdef SHIFTER_CARRY_OUT_EN
                    // Later enabled levels overwrite this, so the last one wins
                    carry_d = (src_op == OP_SLL) ? src_data[WIDTH-AMT] : src_data[AMT-1];
`endif
                end
            end
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                data_q  <= '0;
                shamt_q <= '0;
                op_q    <= OP_SLL;
                tag_q   <= '0;
                sign_q  <= 1'b0;
`ifdef SHIFTER_CARRY_OUT_EN
                carry_q <= 1'b0;
`endif
            end else if (advance) begin
                data_q  <= data_d;
                shamt_q <= shamt_d;
                op_q    <= op_d;
                tag_q   <= tag_d;
                sign_q  <= sign_d;
`ifdef SHIFTER_CARRY_OUT_EN
                carry_q <= carry_d;
`endif
            end
        end
    end

    assign bus.out_valid = vld_pipe_q[SHW-1];
    assign bus.out_data  = g_stg[SHW-1].data_q;
    assign bus.out_tag   = g_stg[SHW-1].tag_q;
`ifdef SHIFTER_CARRY_OUT_EN
    assign bus.out_carry = g_stg[SHW-1].carry_q;
`endif

    // Control fields of the final stage have no consumer
    logic unused_tail;
    assign unused_tail = ^{g_stg[SHW-1].shamt_q, g_stg[SHW-1].op_q, g_stg[SHW-1].sign_q};
endmodule

// File: tb/tb_pipelined_barrel_shifter.sv
// Scoreboard bench for pipelined_barrel_shifter: spec vectors, throughput, backpressure, reset flush.
module tb_pipelined_barrel_shifter;
    localparam int WIDTH = 32;
    localparam int TAG_W = 5;
    localparam int LAT   = 5;

    logic clk, rst_n;
    pipelined_barrel_shifter_if #(.WIDTH(WIDTH), .TAG_W(TAG_W)) bus ();
    pipelined_barrel_shifter #(.WIDTH(WIDTH), .TAG_W(TAG_W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    typedef struct {
        logic [31:0] data;
        logic [4:0]  tag;
        logic        carry;
        int          cyc;
    } exp_t;

    typedef struct {
        logic [31:0] d;
        logic [4:0]  sh;
        logic [1:0]  op;
        logic [31:0] exp_d;
        logic        exp_c;
    } vec_t;

    exp_t        sb[$];
    vec_t        vecs[13];
    int          n_cmp = 0, n_err = 0, cyc = 0;
    int          run = 0, max_run = 0;
    logic        lat_chk, stall_prev;
    logic [31:0] hold_data;
    logic [4:0]  hold_tag;

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: actual %h required %h", name, act, exp);
        end
    endtask

    function automatic logic [32:0] model(input logic [31:0] d, input logic [4:0] sh, input logic [1:0] op);
        logic [31:0] r;
        logic        c;
        int          s;
        s = int'(sh);
        case (op)
            2'd0:    r = d << s;
            2'd1:    r = d >> s;
            2'd2:    r = $signed(d) >>> s;
            default: r = (d >> s) | (d << (32 - s));
        endcase
        if (s == 0)         c = 1'b0;
        else if (op == 2'd0) c = d[32-s];
        else                c = d[s-1];
        return {c, r};
    endfunction

    // One clock: drive, sample handshakes in the low phase, then wait for the next falling edge
    task automatic cycle(input logic v, input logic [31:0] d, input logic [4:0] sh, input logic [1:0] op,
                         input logic [4:0] tag, input logic ordy, input logic [32:0] exp);
        exp_t e;
        bus.in_valid  = v;
        bus.in_data   = d;
        bus.in_shamt  = sh;
        bus.in_op     = op;
        bus.in_tag    = tag;
        bus.out_ready = ordy;
        #1;
        if (stall_prev) begin
            chk("stall_valid", {31'd0, bus.out_valid}, 32'd1);
            chk("stall_data", bus.out_data, hold_data);
            chk("stall_tag", {27'd0, bus.out_tag}, {27'd0, hold_tag});
        end
        stall_prev = bus.out_valid && !bus.out_ready;
        hold_data  = bus.out_data;
        hold_tag   = bus.out_tag;
        if (stall_prev) chk("stall_in_ready", {31'd0, bus.in_ready}, 32'd0);
        if (bus.out_valid) begin
            run++;
            if (run > max_run) max_run = run;
        end else run = 0;
        if (v && bus.in_ready) sb.push_back('{exp[31:0], tag, exp[32], cyc});
        if (bus.out_valid && bus.out_ready) begin
            if (sb.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL spurious_out: actual tag %0d data %h required no output", bus.out_tag, bus.out_data);
            end else begin
                e = sb.pop_front();
                chk("out_data", bus.out_data, e.data);
                chk("out_tag", {27'd0, bus.out_tag}, {27'd0, e.tag});
`ifdef SHIFTER_CARRY_OUT_EN
                chk("out_carry", {31'd0, bus.out_carry}, {31'd0, e.carry});
`endif
                if (lat_chk) chk("latency", cyc - e.cyc, LAT);
            end
        end
        @(negedge clk);
    endtask

    task automatic idle(input int n, input logic ordy);
        for (int i = 0; i < n; i++) cycle(1'b0, $urandom, 5'($urandom), 2'($urandom), 5'($urandom), ordy, 33'd0);
    endtask

    task automatic drain();
        int guard = 0;
        while (sb.size() > 0 && guard < 60) begin
            idle(1, 1'b1);
            guard++;
        end
        chk("drain_left", sb.size(), 0);
    endtask

    initial begin
        logic [31:0] d;
        logic [4:0]  sh;
        logic [1:0]  op;
        vecs[0]  = '{32'h8000_00F1, 5'd4,  2'd0, 32'h0000_0F10, 1'b0};
        vecs[1]  = '{32'h8000_00F1, 5'd4,  2'd1, 32'h0800_000F, 1'b0};
        vecs[2]  = '{32'h8000_00F1, 5'd4,  2'd2, 32'hF800_000F, 1'b0};
        vecs[3]  = '{32'h8000_00F1, 5'd4,  2'd3, 32'h1800_000F, 1'b0};
        vecs[4]  = '{32'hDEAD_BEEF, 5'd0,  2'd0, 32'hDEAD_BEEF, 1'b0};
        vecs[5]  = '{32'hDEAD_BEEF, 5'd0,  2'd1, 32'hDEAD_BEEF, 1'b0};
        vecs[6]  = '{32'hDEAD_BEEF, 5'd0,  2'd2, 32'hDEAD_BEEF, 1'b0};
        vecs[7]  = '{32'hDEAD_BEEF, 5'd0,  2'd3, 32'hDEAD_BEEF, 1'b0};
        vecs[8]  = '{32'h8000_0000, 5'd31, 2'd2, 32'hFFFF_FFFF, 1'b0};
        vecs[9]  = '{32'h0000_0001, 5'd31, 2'd0, 32'h8000_0000, 1'b0};
        vecs[10] = '{32'h0000_0008, 5'd4,  2'd1, 32'h0000_0000, 1'b1};
        vecs[11] = '{32'h4000_0000, 5'd1,  2'd0, 32'h8000_0000, 1'b0};
        vecs[12] = '{32'h4000_0000, 5'd2,  2'd0, 32'h0000_0000, 1'b1};

        rst_n = 1'b0; lat_chk = 1'b1; stall_prev = 1'b0;
        bus.in_valid = 1'b0; bus.in_data = '0; bus.in_shamt = '0;
        bus.in_op = '0; bus.in_tag = '0; bus.out_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #1;
        chk("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
        chk("rst_in_ready", {31'd0, bus.in_ready}, 32'd1);
        chk("rst_out_data", bus.out_data, 32'd0);
        chk("rst_out_tag", {27'd0, bus.out_tag}, 32'd0);
`ifdef SHIFTER_CARRY_OUT_EN
        chk("rst_out_carry", {31'd0, bus.out_carry}, 32'd0);
`endif
        rst_n = 1'b1;
        @(negedge clk);

        // Spec vectors back to back, fixed latency expected
        for (int i = 0; i < 13; i++)
            cycle(1'b1, vecs[i].d, vecs[i].sh, vecs[i].op, 5'(i), 1'b1, {vecs[i].exp_c, vecs[i].exp_d});
        drain();

        // Throughput: 20 random ops, outputs must be one unbroken run
        run = 0; max_run = 0;
        for (int i = 0; i < 20; i++) begin
            d = $urandom; sh = 5'($urandom_range(0, 31)); op = 2'($urandom_range(0, 3));
            cycle(1'b1, d, sh, op, 5'(i), 1'b1, model(d, sh, op));
        end
        drain();
        chk("thru_run", max_run, 20);

        // Backpressure: fill, stall 7 cycles, release with more traffic
        lat_chk = 1'b0;
        for (int i = 0; i < 5; i++) begin
            d = $urandom; sh = 5'($urandom_range(1, 31)); op = 2'($urandom_range(0, 3));
            cycle(1'b1, d, sh, op, 5'(i), 1'b1, model(d, sh, op));
        end
        for (int i = 0; i < 7; i++) begin
            d = $urandom; sh = 5'($urandom_range(0, 31));
            cycle(1'b1, d, sh, 2'd3, 5'd31, 1'b0, model(d, sh, 2'd3));
        end
        for (int i = 5; i < 15; i++) begin
            d = $urandom; sh = 5'($urandom_range(0, 31)); op = 2'($urandom_range(0, 3));
            cycle(1'b1, d, sh, op, 5'(i), 1'b1, model(d, sh, op));
        end
        drain();

        // Reset mid-stream with the pipeline full: everything in flight is discarded
        lat_chk = 1'b1;
        for (int i = 0; i < 5; i++) begin
            d = $urandom; sh = 5'($urandom_range(0, 31)); op = 2'($urandom_range(0, 3));
            cycle(1'b1, d, sh, op, 5'(i + 20), 1'b1, model(d, sh, op));
        end
        bus.in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", {31'd0, bus.out_valid}, 32'd0);
        chk("midrst_in_ready", {31'd0, bus.in_ready}, 32'd1);
        chk("midrst_out_data", bus.out_data, 32'd0);
        sb.delete();
        stall_prev = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        idle(10, 1'b1);
        chk("post_rst_idle", {31'd0, bus.out_valid}, 32'd0);

        // A single op after reset still flows normally
        cycle(1'b1, 32'h8000_00F1, 5'd4, 2'd2, 5'd7, 1'b1, {1'b0, 32'hF800_000F});
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
